// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32 multi-cycle control sequencer.
package rv32_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT_INSTR,
        S_EXECUTE,
        S_LOAD,
        S_WAIT_LOAD,
        S_STORE,
        S_WAIT_STORE,
        S_HALT
    } seq_state_t;

    localparam logic [1:0]  WB_ALU = 2'd0;
    localparam logic [1:0]  WB_MEM = 2'd1;
    localparam logic [1:0]  WB_PC4 = 2'd2;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/core_sequencer_if.sv
// Memory bus between the sequencer (master) and the instruction/data memory (slave).
interface core_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rstrb;
    logic [3:0]            mem_wmask;
    logic [31:0]           mem_rdata;
    logic                  mem_rbusy;
    logic                  mem_wbusy;

    modport master (
        output mem_addr, mem_rstrb, mem_wmask,
        input  mem_rdata, mem_rbusy, mem_wbusy
    );

    modport slave (
        input  mem_addr, mem_rstrb, mem_wmask,
        output mem_rdata, mem_rbusy, mem_wbusy
    );
endinterface

// File: rtl/store_mask_gen.sv
// Byte write-enable generation for SB/SH/SW from func3[1:0] and the low address bits.
module store_mask_gen (
    input  logic [1:0] size,
    input  logic [1:0] addr,
    output logic [3:0] mask,
    output logic       misaligned
);

    always_comb begin
        mask       = 4'b0000;
        misaligned = 1'b0;
        case (size)
            2'd0: mask = 4'b0001 << addr;
            2'd1: begin
                mask       = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            2'd2: begin
                mask       = 4'b1111;
                misaligned = |addr;
            end
            default: begin
                mask       = 4'b0000;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer for the rv32 core; owns PC and instruction register.
// Optional macro RV32_MISALIGN_TRAP_EN: misaligned jump targets and stores halt with a sticky trap.
//
// state        | meaning
// -------------+-----------------------------------------------
// S_FETCH      | drive PC on the bus, pulse read strobe
// S_WAIT_INSTR | wait for instruction read, latch instr
// S_EXECUTE    | decoder valid; retire non-memory ops, update PC
// S_LOAD       | drive load address, pulse read strobe
// S_WAIT_LOAD  | wait for load data, write back, PC+4
// S_STORE      | drive store address and byte mask for one cycle
// S_WAIT_STORE | wait for write completion, PC+4
// S_HALT       | trapped; only reset leaves
module core_sequencer
    import rv32_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = RESET_ADDR_DEFAULT[ADDR_WIDTH-1:0]
) (
    input  logic                  clk,
    input  logic                  rst,
    core_sequencer_if.master      bus,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic                  is_branch,
    input  logic                  is_jal,
    input  logic                  is_jalr,
    input  logic [2:0]            func3,
    input  logic                  dec_wb_en,
    input  logic                  take_branch,
    input  logic [31:0]           alu_out,
    input  logic [31:0]           imm,
    output logic                  write_back,
    output logic [1:0]            wb_sel,
    output logic                  trap
);

    seq_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q;

    logic [ADDR_WIDTH-1:0] pc_plus4, pc_plus_imm, jalr_tgt, raw_target;
    logic                  xfer_taken;
    logic [3:0]            st_mask;
    logic                  st_misaligned;

    logic                  rstrb_c, wb_c;
    logic [3:0]            wmask_c;
    logic                  trap_set;

    logic                  unused_func3;
    assign unused_func3 = func3[2];

    store_mask_gen u_store_mask_gen (
        .size       (func3[1:0]),
        .addr       (alu_out[1:0]),
        .mask       (st_mask),
        .misaligned (st_misaligned)
    );

    assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
    assign pc_plus_imm = pc_q + imm[ADDR_WIDTH-1:0];
    assign jalr_tgt    = {alu_out[ADDR_WIDTH-1:1], 1'b0};
    assign xfer_taken  = is_jal | is_jalr | (is_branch & take_branch);
    assign raw_target  = is_jalr ? jalr_tgt : pc_plus_imm;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rstrb_c      = 1'b0;
        wmask_c      = 4'b0000;
        wb_c         = 1'b0;
        wb_sel       = WB_ALU;
        bus.mem_addr = pc_q;
        trap_set     = 1'b0;
        case (state_q)
            S_FETCH: begin
                rstrb_c = 1'b1;
                state_d = S_WAIT_INSTR;
            end
            S_WAIT_INSTR: begin
                if (!bus.mem_rbusy) state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_load) begin
                    state_d = S_LOAD;
                end else if (is_store) begin
                    state_d = S_STORE;
                end else begin
                    if (is_jal || is_jalr) wb_sel = WB_PC4;
`ifdef RV32_MISALIGN_TRAP_EN
                    if (xfer_taken && raw_target[1]) begin
                        trap_set = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        wb_c    = dec_wb_en;
                        pc_d    = xfer_taken ? raw_target : pc_plus4;
                        state_d = S_FETCH;
                    end
`else
                    wb_c    = dec_wb_en;
                    pc_d    = xfer_taken ? (raw_target & ~ADDR_WIDTH'(3)) : pc_plus4;
                    state_d = S_FETCH;
`endif
                end
            end
            S_LOAD: begin
                bus.mem_addr = alu_out[ADDR_WIDTH-1:0];
                rstrb_c      = 1'b1;
                state_d      = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                bus.mem_addr = alu_out[ADDR_WIDTH-1:0];
                wb_sel       = WB_MEM;
                if (!bus.mem_rbusy) begin
                    wb_c    = dec_wb_en;
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            S_STORE: begin
                bus.mem_addr = alu_out[ADDR_WIDTH-1:0];
`ifdef RV32_MISALIGN_TRAP_EN
                if (st_misaligned) begin
                    trap_set = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    wmask_c = st_mask;
                    state_d = S_WAIT_STORE;
                end
`else
                wmask_c = st_mask;
                state_d = S_WAIT_STORE;
`endif
            end
            S_WAIT_STORE: begin
                bus.mem_addr = alu_out[ADDR_WIDTH-1:0];
                if (!bus.mem_wbusy) begin
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_ADDR;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_WAIT_INSTR && !bus.mem_rbusy) instr_q <= bus.mem_rdata;
        end
    end

`ifdef RV32_MISALIGN_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           trap_q <= 1'b0;
        else if (trap_set) trap_q <= 1'b1;
    end
    assign trap = trap_q;
`else
    logic unused_trap;
    assign unused_trap = trap_set | st_misaligned;
    assign trap        = 1'b0;
`endif

    // Reset gates the strobes so an abandoned transaction drops in the same cycle.
    assign bus.mem_rstrb = rstrb_c & ~rst;
    assign bus.mem_wmask = rst ? 4'b0000 : wmask_c;
    assign write_back    = wb_c & ~rst;
    assign pc            = pc_q;
    assign instr         = instr_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: memory and decoder are driven by hand, expectations hand-computed.
module tb_core_sequencer;
    import rv32_pkg::*;

    logic        clk, rst;
    logic [31:0] instr, pc, alu_out, imm;
    logic        is_load, is_store, is_branch, is_jal, is_jalr;
    logic [2:0]  func3;
    logic        dec_wb_en, take_branch, write_back, trap;
    logic [1:0]  wb_sel;

    core_sequencer_if bus ();

    core_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .instr       (instr),
        .pc          (pc),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_branch   (is_branch),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .func3       (func3),
        .dec_wb_en   (dec_wb_en),
        .take_branch (take_branch),
        .alu_out     (alu_out),
        .imm         (imm),
        .write_back  (write_back),
        .wb_sel      (wb_sel),
        .trap        (trap)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edges    = 0;
    int          e0;
    logic [31:0] exp_pc;
    logic [31:0] last_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_dec();
        is_load         = 1'b0;
        is_store        = 1'b0;
        is_branch       = 1'b0;
        is_jal          = 1'b0;
        is_jalr         = 1'b0;
        func3           = 3'd0;
        dec_wb_en       = 1'b0;
        take_branch     = 1'b0;
        alu_out         = 32'h0;
        imm             = 32'h0;
        bus.mem_rbusy   = 1'b0;
        bus.mem_wbusy   = 1'b0;
        bus.mem_rdata   = 32'h0;
    endtask

    // Entered during a FETCH cycle; returns in the EXECUTE cycle.
    task automatic fetch(input logic [31:0] ins, input int busy);
        chk("fetch_rstrb", bus.mem_rstrb, 1);
        chk("fetch_addr", bus.mem_addr, exp_pc);
        cyc();
        for (int i = 0; i < busy; i++) begin
            bus.mem_rbusy = 1'b1;
            bus.mem_rdata = 32'hDEAD_BEEF;
            settle();
            chk("wait_rstrb", bus.mem_rstrb, 0);
            cyc();
            chk("instr_hold", instr, last_instr);
        end
        bus.mem_rbusy = 1'b0;
        bus.mem_rdata = ins;
        cyc();
        chk("instr_latch", instr, ins);
        last_instr = ins;
    endtask

    task automatic do_store(input logic [31:0] ins, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [3:0] exp_mask, input int wbusy);
        fetch(ins, 0);
        is_store  = 1'b1;
        func3     = f3;
        alu_out   = addr;
        dec_wb_en = 1'b1;
        settle();
        chk("st_exec_wb", write_back, 0);
        cyc();
        chk("st_addr", bus.mem_addr, addr);
        chk("st_mask", bus.mem_wmask, exp_mask);
        chk("st_wb", write_back, 0);
        cyc();
        for (int i = 0; i < wbusy; i++) begin
            bus.mem_wbusy = 1'b1;
            settle();
            chk("st_busy_mask", bus.mem_wmask, 0);
            chk("st_busy_wb", write_back, 0);
            cyc();
            chk("st_busy_pc", pc, exp_pc);
        end
        bus.mem_wbusy = 1'b0;
        settle();
        chk("st_wait_mask", bus.mem_wmask, 0);
        chk("st_wait_wb", write_back, 0);
        cyc();
        exp_pc = exp_pc + 32'd4;
        chk("st_pc", pc, exp_pc);
        clr_dec();
    endtask

    // Non-memory instruction: expects write_back/wb_sel in EXECUTE and the given next PC.
    task automatic do_exec(input logic [31:0] ins, input logic exp_wb, input logic [1:0] exp_sel,
                           input logic [31:0] next_pc);
        settle();
        chk("ex_wb", write_back, exp_wb);
        chk("ex_wb_sel", wb_sel, exp_sel);
        chk("ex_instr", instr, ins);
        cyc();
        exp_pc = next_pc;
        chk("ex_pc", pc, exp_pc);
        chk("ex_wb_after", write_back, 0);
        clr_dec();
    endtask

    initial begin
        rst        = 1'b1;
        clr_dec();
        exp_pc     = 32'h0;
        last_instr = NOP_INSTR;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_rstrb", bus.mem_rstrb, 0);
        chk("rst_wmask", bus.mem_wmask, 0);
        chk("rst_wb", write_back, 0);
        chk("rst_trap", trap, 0);
        chk("rst_wb_sel", wb_sel, 0);

        rst = 1'b0;
        settle();
        // ADDI x1, x0, 1 at address 0, zero-wait
        e0 = edges;
        fetch(32'h0010_0093, 0);
        chk("addi_latency", edges - e0, 2);
        dec_wb_en = 1'b1;
        do_exec(32'h0010_0093, 1'b1, WB_ALU, 32'h4);

        // ADD with three busy fetch cycles
        e0 = edges;
        fetch(32'h0020_81B3, 3);
        chk("busy_latency", edges - e0, 5);
        dec_wb_en = 1'b1;
        do_exec(32'h0020_81B3, 1'b1, WB_ALU, 32'h8);

        // LW from 0x100
        fetch(32'h1000_2103, 0);
        is_load   = 1'b1;
        alu_out   = 32'h100;
        dec_wb_en = 1'b1;
        settle();
        chk("ld_exec_wb", write_back, 0);
        cyc();
        chk("ld_addr", bus.mem_addr, 32'h100);
        chk("ld_rstrb", bus.mem_rstrb, 1);
        cyc();
        bus.mem_rbusy = 1'b0;
        settle();
        chk("ld_wb", write_back, 1);
        chk("ld_wb_sel", wb_sel, WB_MEM);
        chk("ld_pc_hold", pc, 32'h8);
        cyc();
        exp_pc = 32'hC;
        chk("ld_pc", pc, exp_pc);
        clr_dec();

        do_store(32'h0020_01A3, 3'd0, 32'h103, 4'b1000, 0);
        do_store(32'h0020_1123, 3'd1, 32'h102, 4'b1100, 0);
        do_store(32'h2020_2023, 3'd2, 32'h200, 4'b1111, 2);

        // JAL from 0x18 to 0x40
        fetch(32'h0280_00EF, 0);
        is_jal = 1'b1; imm = 32'h28; dec_wb_en = 1'b1;
        do_exec(32'h0280_00EF, 1'b1, WB_PC4, 32'h40);

        // BEQ taken, imm -8: 0x40 -> 0x38
        fetch(32'hFE00_0CE3, 0);
        is_branch = 1'b1; take_branch = 1'b1; imm = 32'hFFFF_FFF8;
        do_exec(32'hFE00_0CE3, 1'b0, WB_ALU, 32'h38);

        // BNE not taken: 0x38 -> 0x3C
        fetch(32'hFE10_9CE3, 0);
        is_branch = 1'b1; take_branch = 1'b0; imm = 32'hFFFF_FFF8;
        do_exec(32'hFE10_9CE3, 1'b0, WB_ALU, 32'h3C);

        fetch(NOP_INSTR, 0);
        do_exec(NOP_INSTR, 1'b0, WB_ALU, 32'h40);

        // JAL imm 0x10 from 0x40
        fetch(32'h0100_00EF, 0);
        is_jal = 1'b1; imm = 32'h10; dec_wb_en = 1'b1;
        do_exec(32'h0100_00EF, 1'b1, WB_PC4, 32'h50);

        // JALR to 0xFFFF_FFFD: bit 0 cleared, then PC+4 wraps to 0
        fetch(32'h0000_80E7, 0);
        is_jalr = 1'b1; alu_out = 32'hFFFF_FFFD; dec_wb_en = 1'b1;
        do_exec(32'h0000_80E7, 1'b1, WB_PC4, 32'hFFFF_FFFC);
        fetch(NOP_INSTR, 0);
        do_exec(NOP_INSTR, 1'b0, WB_ALU, 32'h0);

        fetch(32'h0400_006F, 0);
        is_jal = 1'b1; imm = 32'h40;
        do_exec(32'h0400_006F, 1'b0, WB_PC4, 32'h40);

        // JALR to 0x43 -> target 0x42
        fetch(32'h0000_80E7, 0);
        is_jalr = 1'b1; alu_out = 32'h43; dec_wb_en = 1'b1;
        settle();
`ifdef RV32_MISALIGN_TRAP_EN
        chk("trap_exec_wb", write_back, 0);
        cyc();
        chk("trap_flag", trap, 1);
        chk("trap_pc", pc, 32'h40);
        chk("trap_rstrb", bus.mem_rstrb, 0);
        clr_dec();
        bus.mem_rbusy = 1'b1;
        repeat (3) cyc();
        chk("halt_trap", trap, 1);
        chk("halt_pc", pc, 32'h40);
        chk("halt_rstrb", bus.mem_rstrb, 0);
        chk("halt_wmask", bus.mem_wmask, 0);
        chk("halt_wb", write_back, 0);
        rst = 1'b1;
        settle();
        chk("halt_rst_trap", trap, 0);
        cyc();
        rst = 1'b0;
        clr_dec();
        exp_pc     = 32'h0;
        last_instr = NOP_INSTR;
        settle();
`else
        chk("jalr_mis_wb", write_back, 1);
        chk("jalr_mis_sel", wb_sel, WB_PC4);
        cyc();
        exp_pc = 32'h40;
        chk("jalr_mis_pc", pc, exp_pc);
        chk("jalr_mis_trap", trap, 0);
        clr_dec();
`endif

        // Reset in the middle of WAIT_STORE
        fetch(32'h2020_2023, 0);
        is_store = 1'b1; func3 = 3'd2; alu_out = 32'h300;
        cyc();
        chk("rs_mask", bus.mem_wmask, 4'b1111);
        cyc();
        bus.mem_wbusy = 1'b1;
        settle();
        chk("rs_pc_pre", pc, exp_pc);
        rst = 1'b1;
        settle();
        chk("rs_wmask", bus.mem_wmask, 0);
        chk("rs_rstrb", bus.mem_rstrb, 0);
        chk("rs_wb", write_back, 0);
        chk("rs_pc", pc, 32'h0);
        chk("rs_instr", instr, NOP_INSTR);
        cyc();
        rst = 1'b0;
        clr_dec();
        exp_pc     = 32'h0;
        last_instr = NOP_INSTR;
        settle();
        fetch(32'h0010_0093, 0);
        dec_wb_en = 1'b1;
        do_exec(32'h0010_0093, 1'b1, WB_ALU, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
